// File: rtl/kros_seq_ctrl.sv
// Front-panel controller for the KROS LED sequencer: debounces four active-low
// buttons into freq/pattern select steps and generates the step tick and index.
module kros_seq_ctrl #(
  parameter int DEB_CYCLES = 250,
  parameter int TICK_BASE  = 8,
  parameter int FREQ_RST   = 4,
  parameter int NSEQ       = 6,
  parameter int SEQ_LEN    = 10
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       pb_freq_up,
  input  logic       pb_freq_dn,
  input  logic       pb_seq_up,
  input  logic       pb_seq_dn,
  output logic [2:0] freq_sel,
  output logic [2:0] seq_sel,
  output logic       tick,
  output logic [3:0] step,
  output logic       cfg_pulse,
  output logic [7:0] deb_state
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam int DCW  = $clog2(DEB_CYCLES + 1);
  localparam int DIVW = $clog2(TICK_BASE << 7);

  logic [3:0] raw;
  logic [3:0] ev;
  logic [1:0] settle;

  assign raw = {pb_seq_dn, pb_seq_up, pb_freq_dn, pb_freq_up};

  // The sync flops hold their reset value for two cycles; a button may only arm
  // once a genuine released level has come through, so a hold across reset is ignored.
  always_ff @(posedge CLK_50) begin
    if (reset) settle <= 2'd0;
    else if (settle != 2'd2) settle <= settle + 2'd1;
  end

  for (genvar b = 0; b < 4; b++) begin : g_deb
    logic           sync1, sync2, armed, ev_q;
    logic [DCW-1:0] cnt, cnt_nxt;
    deb_state_t     state, state_nxt;

    always_ff @(posedge CLK_50) begin
      if (reset) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
        armed <= 1'b0;
        state <= RELEASED;
        cnt   <= '0;
        ev_q  <= 1'b0;
      end else begin
        sync1 <= raw[b];
        sync2 <= sync1;
        armed <= armed | ((settle == 2'd2) & sync2);
        state <= state_nxt;
        cnt   <= cnt_nxt;
        ev_q  <= (state == PRESS_WAIT) && (state_nxt == PRESSED);
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      unique case (state)
        RELEASED: begin
          if (!sync2 && armed) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = DCW'(1);
          end
        end
        PRESS_WAIT: begin
          if (sync2) state_nxt = RELEASED;
          else if (cnt == DCW'(DEB_CYCLES - 1)) state_nxt = PRESSED;
          else cnt_nxt = cnt + DCW'(1);
        end
        PRESSED: begin
          if (sync2) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = DCW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (!sync2) state_nxt = PRESSED;
          else if (cnt == DCW'(DEB_CYCLES - 1)) state_nxt = RELEASED;
          else cnt_nxt = cnt + DCW'(1);
        end
      endcase
    end

    assign ev[b]             = ev_q;
    assign deb_state[2*b+:2] = state;
  end

  logic            f_up, f_dn, s_up, s_dn, f_chg, s_chg;
  logic [DIVW-1:0] div_cnt, period_m1;

  // Opposing events in one pair cancel each other.
  assign f_up  = ev[0] & ~ev[1];
  assign f_dn  = ev[1] & ~ev[0];
  assign s_up  = ev[2] & ~ev[3];
  assign s_dn  = ev[3] & ~ev[2];
  assign f_chg = (f_up && freq_sel != 3'd7) || (f_dn && freq_sel != 3'd0);
  assign s_chg = s_up | s_dn;

  assign period_m1 = DIVW'((TICK_BASE << (3'd7 - freq_sel)) - 1);

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      freq_sel  <= 3'(FREQ_RST);
      seq_sel   <= 3'd0;
      step      <= 4'd0;
      tick      <= 1'b0;
      cfg_pulse <= 1'b0;
      div_cnt   <= '0;
    end else begin
      cfg_pulse <= f_chg | s_chg;
      if (f_chg) freq_sel <= f_up ? freq_sel + 3'd1 : freq_sel - 3'd1;

      // A rate change restarts the period and cancels any tick due this cycle.
      if (f_chg) begin
        div_cnt <= '0;
        tick    <= 1'b0;
      end else if (div_cnt == period_m1) begin
        div_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + DIVW'(1);
        tick    <= 1'b0;
      end

      if (s_chg) begin
        if (s_up) seq_sel <= (seq_sel == 3'(NSEQ - 1)) ? 3'd0 : seq_sel + 3'd1;
        else      seq_sel <= (seq_sel == 3'd0) ? 3'(NSEQ - 1) : seq_sel - 3'd1;
        step <= 4'd0;
      end else if (!f_chg && div_cnt == period_m1) begin
        step <= (step == 4'(SEQ_LEN - 1)) ? 4'd0 : step + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_kros_seq_ctrl.sv
// Bench for kros_seq_ctrl: directed front-panel scenarios plus random button
// activity, all checked every cycle against a timeline-based reference model.
module tb_kros_seq_ctrl;

  localparam int DEB      = 250;
  localparam int FREQ_RST = 4;
  localparam int NSEQ     = 6;
  localparam int SEQ_LEN  = 10;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pb = 4'hF;   // {seq_dn, seq_up, freq_dn, freq_up}, active-low
  logic [2:0] freq_sel, seq_sel;
  logic [3:0] step;
  logic       tick, cfg_pulse;
  logic [7:0] deb_state;

  always #10 clk = ~clk;

  kros_seq_ctrl dut (
    .CLK_50    (clk),
    .reset     (reset),
    .pb_freq_up(pb[0]),
    .pb_freq_dn(pb[1]),
    .pb_seq_up (pb[2]),
    .pb_seq_dn (pb[3]),
    .freq_sel  (freq_sel),
    .seq_sel   (seq_sel),
    .tick      (tick),
    .step      (step),
    .cfg_pulse (cfg_pulse),
    .deb_state (deb_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int period(input int f);
    return 8 << (7 - f);
  endfunction

  // ---------------- reference model ----------------
  // Inputs captured at the active edge; the model advances half a cycle later.
  logic       cap_rst = 1'b0;
  logic [3:0] cap_raw = 4'hF;
  always @(posedge clk) begin
    cap_rst <= reset;
    cap_raw <= pb;
  end

  bit         model_on = 0;
  int         edge_no, next_tick;
  int         m_freq, m_seq, m_step;
  bit         m_tick, m_cfg;
  logic [3:0] raw_hist[$];
  bit         prev[4], deb[4], seen[4], pend[4];
  int         run[4];

  always @(negedge clk) begin
    if (cap_rst) begin
      model_on  = 1;
      edge_no   = 0;
      m_freq    = FREQ_RST;
      m_seq     = 0;
      m_step    = 0;
      m_tick    = 0;
      m_cfg     = 0;
      next_tick = period(FREQ_RST);
      raw_hist.delete();
      for (int b = 0; b < 4; b++) begin
        prev[b] = 1; deb[b] = 1; seen[b] = 0; pend[b] = 0; run[b] = 0;
      end
    end else if (model_on) begin
      bit f_up, f_dn, s_up, s_dn, f_chg, s_chg;
      int new_f;
      edge_no++;
      // Button events recognised on the previous edge take effect now.
      f_up  = pend[0] && !pend[1];
      f_dn  = pend[1] && !pend[0];
      s_up  = pend[2] && !pend[3];
      s_dn  = pend[3] && !pend[2];
      new_f = m_freq;
      if (f_up && m_freq < 7) new_f = m_freq + 1;
      if (f_dn && m_freq > 0) new_f = m_freq - 1;
      f_chg = (new_f != m_freq);
      s_chg = s_up || s_dn;
      m_freq = new_f;
      if (s_up) m_seq = (m_seq + 1) % NSEQ;
      if (s_dn) m_seq = (m_seq + NSEQ - 1) % NSEQ;
      m_cfg = f_chg || s_chg;
      if (f_chg) begin
        m_tick    = 0;
        next_tick = edge_no + period(m_freq);
      end else if (edge_no == next_tick) begin
        m_tick    = 1;
        next_tick = edge_no + period(m_freq);
      end else begin
        m_tick = 0;
      end
      if (s_chg) m_step = 0;
      else if (m_tick) m_step = (m_step + 1) % SEQ_LEN;

      // Debounced level follows a synchronised level once it has held DEB samples;
      // a button only counts after it has been seen released since reset.
      raw_hist.push_back(cap_raw);
      for (int b = 0; b < 4; b++) begin
        bit s;
        s = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size() - 3][b] : 1'b1;
        run[b]  = (s == prev[b]) ? run[b] + 1 : 1;
        prev[b] = s;
        pend[b] = 0;
        if (seen[b] && s != deb[b] && run[b] >= DEB) begin
          deb[b]  = s;
          pend[b] = !s;
        end
        if (s && edge_no >= 3) seen[b] = 1;
      end
      if (raw_hist.size() > 3) void'(raw_hist.pop_front());
    end

    if (model_on) begin
      check("freq_sel", freq_sel, m_freq);
      check("seq_sel", seq_sel, m_seq);
      check("step", step, m_step);
      check("tick", tick, m_tick);
      check("cfg_pulse", cfg_pulse, m_cfg);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input logic [3:0] mask, input int len, input int glitch_at,
                       input int settle, output int ncfg);
    ncfg = 0;
    for (int i = 0; i < len; i++) begin
      pb = (glitch_at > 0 && i == glitch_at) ? 4'hF : ~mask;
      @(negedge clk);
      if (cfg_pulse) ncfg++;
    end
    pb = 4'hF;
    for (int i = 0; i < settle; i++) begin
      @(negedge clk);
      if (cfg_pulse) ncfg++;
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 3000);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  task automatic measure_period(output int p);
    int n;
    wait_tick(n);
    wait_tick(p);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, p, ncfg;
    repeat (4) @(negedge clk);
    check("rst_freq", freq_sel, 4);
    check("rst_seq", seq_sel, 0);
    check("rst_step", step, 0);
    check("rst_tick", tick, 0);
    check("rst_cfg", cfg_pulse, 0);
    reset = 1'b0;

    // Idle after reset: tick every 64 cycles, step wraps after 10 ticks.
    wait_tick(n);
    check("first_tick_at", n, 64);
    check("step_after_1", step, 1);
    wait_tick(n);
    check("second_tick_gap", n, 64);
    for (int i = 0; i < 8; i++) wait_tick(n);
    check("step_wrap", step, 0);

    // Single long seq_up hold: event 253 cycles after the press.
    pb = 4'b1011;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_pulse && n < 600);
    check("seq_latency", n, 253);
    check("seq_up_val", seq_sel, 1);
    check("seq_up_step", step, 0);
    @(negedge clk);
    check("cfg_one_cycle", cfg_pulse, 0);
    repeat (246) @(negedge clk);
    press(4'b0100, 1, 0, DEB + 20, ncfg);
    check("seq_single_event", seq_sel, 1);

    // Short freq pulse ignored; glitch inside a long hold still one event.
    press(4'b0001, 100, 0, DEB + 20, ncfg);
    check("short_pulse_freq", freq_sel, 4);
    check("short_pulse_cfg", ncfg, 0);
    press(4'b0001, 500, 350, DEB + 20, ncfg);
    check("glitch_freq", freq_sel, 5);
    check("glitch_cfg", ncfg, 1);
    measure_period(p);
    check("period_f5", p, 32);
    press(4'b0001, 400, 0, DEB + 20, ncfg);
    measure_period(p);
    check("period_f6", p, 16);
    press(4'b0001, 400, 0, DEB + 20, ncfg);
    check("freq_7", freq_sel, 7);
    measure_period(p);
    check("period_f7", p, 8);
    press(4'b0001, 400, 0, DEB + 20, ncfg);
    check("freq_sat_hi", freq_sel, 7);
    check("freq_sat_hi_cfg", ncfg, 0);

    for (int i = 0; i < 8; i++) press(4'b0010, 300, 0, DEB + 20, ncfg);
    check("freq_sat_lo", freq_sel, 0);
    check("freq_sat_lo_cfg", ncfg, 0);
    measure_period(p);
    check("period_f0", p, 1024);

    // Pattern wrap downwards and cancelled opposite presses.
    press(4'b1000, 300, 0, DEB + 20, ncfg);
    check("seq_dn_0", seq_sel, 0);
    press(4'b1000, 300, 0, DEB + 20, ncfg);
    check("seq_dn_wrap", seq_sel, 5);
    press(4'b1100, 300, 0, DEB + 20, ncfg);
    check("seq_both_val", seq_sel, 5);
    check("seq_both_cfg", ncfg, 0);

    // Freq and seq in the same cycle: both apply, one pulse.
    press(4'b0101, 300, 0, DEB + 20, ncfg);
    check("dual_freq", freq_sel, 1);
    check("dual_seq", seq_sel, 0);
    check("dual_cfg", ncfg, 1);

    // Reset in the middle of a hold discards it.
    press(4'b0100, 300, 0, DEB + 20, ncfg);
    check("pre_rst_seq", seq_sel, 1);
    pb = 4'b1011;
    repeat (150) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("mid_rst_freq", freq_sel, 4);
    check("mid_rst_seq", seq_sel, 0);
    press(4'b0100, 350, 0, DEB + 20, ncfg);
    check("held_thru_rst_cfg", ncfg, 0);
    check("held_thru_rst_seq", seq_sel, 0);
    press(4'b0100, 300, 0, DEB + 20, ncfg);
    check("repress_seq", seq_sel, 1);
    check("repress_cfg", ncfg, 1);

    // Random button activity, occasional resets; model checks every cycle.
    for (int k = 0; k < 24; k++) begin
      int op, len, gl;
      logic [3:0] mask;
      op = $urandom_range(0, 9);
      if (op == 9) begin
        pb = 4'($urandom_range(0, 15));
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
        repeat ($urandom_range(1, 200)) @(negedge clk);
        continue;
      end
      case (op)
        0, 1:    mask = 4'b0001;
        2:       mask = 4'b0010;
        3, 4:    mask = 4'b0100;
        5:       mask = 4'b1000;
        6:       mask = 4'b0011;
        7:       mask = 4'b1100;
        default: mask = 4'($urandom_range(1, 15));
      endcase
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 240) : $urandom_range(255, 600);
      gl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      press(mask, len, gl, $urandom_range(20, 320), ncfg);
    end

    repeat (300) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
